// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: glyph table,
// the all-unlit segment pattern and the nibble-to-glyph lookup.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Active-high pattern with every segment unlit.
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Hex glyphs 0..F, bit6..bit0 = segments A..G, active-high.
  localparam logic [SEG_W-1:0] GLYPH_ROM [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic logic [SEG_W-1:0] seg7_glyph(input logic [3:0] nibble);
    return GLYPH_ROM[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load/display bus of seg7_scan_driver. The blink mask exists only when
// SEG7_BLINK_EN is defined.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                    i_Load;
  logic [4*NUM_DIGITS-1:0] i_Value;
  logic [NUM_DIGITS-1:0]   i_Blank_Mask;
`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0]   i_Blink_Mask;
`endif
  logic [SEG_W-1:0]        o_Segment;
  logic [NUM_DIGITS-1:0]   o_Digit_En;
  logic                    o_Frame_Done;

  // Host side: game logic supplying values and watching the frame pulse.
  modport master (
`ifdef SEG7_BLINK_EN
    output i_Blink_Mask,
`endif
    output i_Load, i_Value, i_Blank_Mask,
    input  o_Segment, o_Digit_En, o_Frame_Done
  );

  // Driver side: the scan driver itself.
  modport slave (
`ifdef SEG7_BLINK_EN
    input  i_Blink_Mask,
`endif
    input  i_Load, i_Value, i_Blank_Mask,
    output o_Segment, o_Digit_En, o_Frame_Done
  );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot/digit sequencer: slot counter, digit index, dead-time flag and the
// frame-wrap indication (last clock of the last digit's slot).
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 2,
  localparam int CNT_W         = $clog2(CLKS_PER_DIGIT),
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  output logic [IDX_W-1:0] o_Digit_Idx,
  output logic             o_Dead,
  output logic             o_Frame_Wrap
);

  logic [CNT_W-1:0] r_Slot_Cnt;
  logic [IDX_W-1:0] r_Digit_Idx;
  logic             w_Slot_Last;
  logic             w_Idx_Last;

  assign w_Slot_Last  = (r_Slot_Cnt == CNT_W'(CLKS_PER_DIGIT - 1));
  assign w_Idx_Last   = (r_Digit_Idx == IDX_W'(NUM_DIGITS - 1));
  assign o_Frame_Wrap = w_Slot_Last && w_Idx_Last;
  assign o_Digit_Idx  = r_Digit_Idx;

  // With no dead time the enables are never held off.
  generate
    if (DEAD_CLKS == 0) begin : g_no_dead
      assign o_Dead = 1'b0;
    end else begin : g_dead
      assign o_Dead = (r_Slot_Cnt < CNT_W'(DEAD_CLKS));
    end
  endgenerate

  // Advance the slot counter; step the digit index on each slot wrap.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Slot_Cnt  <= '0;
      r_Digit_Idx <= '0;
    end else if (w_Slot_Last) begin
      r_Slot_Cnt  <= '0;
      r_Digit_Idx <= w_Idx_Last ? '0 : r_Digit_Idx + IDX_W'(1);
    end else begin
      r_Slot_Cnt  <= r_Slot_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with tear-free loading,
// leading-zero and per-digit blanking, dead time and pin polarity.
// Optional blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int CLKS_PER_DIGIT  = 25000,
  parameter int DEAD_CLKS       = 2,
  parameter int LEAD_ZERO_BLANK = 1,
  parameter int SEG_ACTIVE_LOW  = 0,
  parameter int DIG_ACTIVE_LOW  = 1,
  parameter int BLINK_FRAMES    = 64
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SEG_W-1:0] SEG_RST =
    (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] EN_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [IDX_W-1:0]        w_Digit_Idx;
  logic                    w_Dead;
  logic                    w_Frame_Wrap;

  logic [4*NUM_DIGITS-1:0] r_Active_Value, r_Pend_Value;
  logic [NUM_DIGITS-1:0]   r_Active_Blank, r_Pend_Blank;
  logic                    r_Pend_Flag;

  logic [3:0]              w_Nibble;
  logic                    w_Blank_Bit, w_Lead_Zero, w_Above_Zero;
  logic                    w_Blink_Dark, w_Dark;
  logic [SEG_W-1:0]        w_Seg_Lit, w_Seg_Pin;
  logic [NUM_DIGITS-1:0]   w_En_Lit, w_En_Pin;

  logic [SEG_W-1:0]        r_Segment;
  logic [NUM_DIGITS-1:0]   r_Digit_En;
  logic                    r_Frame_Done;

  seg7_scan_timer #(
    .NUM_DIGITS     (NUM_DIGITS),
    .CLKS_PER_DIGIT (CLKS_PER_DIGIT),
    .DEAD_CLKS      (DEAD_CLKS)
  ) u_timer (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .o_Digit_Idx  (w_Digit_Idx),
    .o_Dead       (w_Dead),
    .o_Frame_Wrap (w_Frame_Wrap)
  );

  // Double-buffered display data: loads park in pending and reach the
  // active copy only at a frame wrap, so a frame never mixes two values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Active_Value <= '0;
      r_Active_Blank <= '0;
      r_Pend_Value   <= '0;
      r_Pend_Blank   <= '0;
      r_Pend_Flag    <= 1'b0;
    end else if (bus.i_Load && w_Frame_Wrap) begin
      r_Active_Value <= bus.i_Value;
      r_Active_Blank <= bus.i_Blank_Mask;
      r_Pend_Flag    <= 1'b0;
    end else if (bus.i_Load) begin
      r_Pend_Value   <= bus.i_Value;
      r_Pend_Blank   <= bus.i_Blank_Mask;
      r_Pend_Flag    <= 1'b1;
    end else if (w_Frame_Wrap && r_Pend_Flag) begin
      r_Active_Value <= r_Pend_Value;
      r_Active_Blank <= r_Pend_Blank;
      r_Pend_Flag    <= 1'b0;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [NUM_DIGITS-1:0] r_Active_Blink, r_Pend_Blink;
  logic [BLK_W-1:0]      r_Blink_Cnt;
  logic                  r_Blink_Phase;

  // Blink mask follows the same pending/active handoff as the value.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Active_Blink <= '0;
      r_Pend_Blink   <= '0;
    end else if (bus.i_Load && w_Frame_Wrap) begin
      r_Active_Blink <= bus.i_Blink_Mask;
    end else if (bus.i_Load) begin
      r_Pend_Blink   <= bus.i_Blink_Mask;
    end else if (w_Frame_Wrap && r_Pend_Flag) begin
      r_Active_Blink <= r_Pend_Blink;
    end
  end

  // Count frame wraps; flip the blink phase every BLINK_FRAMES of them.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Blink_Cnt   <= '0;
      r_Blink_Phase <= 1'b0;
    end else if (w_Frame_Wrap) begin
      if (r_Blink_Cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        r_Blink_Cnt   <= '0;
        r_Blink_Phase <= ~r_Blink_Phase;
      end else begin
        r_Blink_Cnt   <= r_Blink_Cnt + BLK_W'(1);
      end
    end
  end

  // Current digit goes dark in the off phase when its blink bit is set.
  always_comb begin
    w_Blink_Dark = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_Blink_Dark = w_Blink_Dark |
        ((w_Digit_Idx == IDX_W'(k)) & r_Blink_Phase & r_Active_Blink[k]);
    end
  end
`else
  logic [31:0] w_unused_blink_frames;
  assign w_unused_blink_frames = BLINK_FRAMES;
  assign w_Blink_Dark = 1'b0;
`endif

  // Select the current digit's nibble and decide whether it is dark;
  // scanning from the top tracks whether every higher nibble is zero.
  always_comb begin
    w_Nibble     = 4'h0;
    w_Blank_Bit  = 1'b0;
    w_Lead_Zero  = 1'b0;
    w_Above_Zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_Nibble    = w_Nibble |
        ({4{w_Digit_Idx == IDX_W'(k)}} & r_Active_Value[4*k +: 4]);
      w_Blank_Bit = w_Blank_Bit |
        ((w_Digit_Idx == IDX_W'(k)) & r_Active_Blank[k]);
      w_Lead_Zero = w_Lead_Zero |
        ((w_Digit_Idx == IDX_W'(k)) & (LEAD_ZERO_BLANK != 0) & (k != 0) &
         w_Above_Zero & (r_Active_Value[4*k +: 4] == 4'h0));
      w_Above_Zero = w_Above_Zero & (r_Active_Value[4*k +: 4] == 4'h0);
    end
    w_Dark    = w_Blank_Bit | w_Lead_Zero | w_Blink_Dark;
    w_Seg_Lit = w_Dark ? SEG_OFF : seg7_glyph(w_Nibble);
    w_Seg_Pin = (SEG_ACTIVE_LOW != 0) ? ~w_Seg_Lit : w_Seg_Lit;
  end

  // One-hot digit enable, held off during the dead time, then polarity.
  always_comb begin
    w_En_Lit = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_En_Lit[k] = !w_Dead && (w_Digit_Idx == IDX_W'(k));
    end
    w_En_Pin = (DIG_ACTIVE_LOW != 0) ? ~w_En_Lit : w_En_Lit;
  end

  // Register all pins together so segments and enables switch on one edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Segment    <= SEG_RST;
      r_Digit_En   <= EN_OFF;
      r_Frame_Done <= 1'b0;
    end else begin
      r_Segment    <= w_Seg_Pin;
      r_Digit_En   <= w_En_Pin;
      r_Frame_Done <= w_Frame_Wrap;
    end
  end

  assign bus.o_Segment    = r_Segment;
  assign bus.o_Digit_En   = r_Digit_En;
  assign bus.o_Frame_Done = r_Frame_Done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 8 clocks/slot, 1 dead
// clock, leading-zero blanking, active-high segments, active-low enables).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CPD = 8;
  localparam int FRAME = ND * CPD;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) u_if ();

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .CLKS_PER_DIGIT(CPD), .DEAD_CLKS(1),
    .LEAD_ZERO_BLANK(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1),
    .BLINK_FRAMES(BF)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (u_if)
  );

  logic [6:0] glyph_tab [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Reference model: position within the frame plus displayed/queued data.
  int         m_cyc;
  int         m_frames;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_blank, m_pblank, m_blink, m_pblink;
  logic        m_flag;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_cyc = 0; m_frames = 0; m_flag = 1'b0;
    m_act = 16'h0; m_pend = 16'h0;
    m_blank = 4'h0; m_pblank = 4'h0; m_blink = 4'h0; m_pblink = 4'h0;
  endtask

  // One clock: predict the pins from the pre-edge model, advance, compare.
  task automatic step();
    logic [6:0]  e_seg;
    logic [3:0]  e_en;
    logic        e_done, dark, wrap, ld;
    logic [15:0] up;
    logic [3:0]  nv, bm, km;
    int d, s;
    ld = u_if.i_Load;
    nv = 4'h0;
`ifdef SEG7_BLINK_EN
    km = u_if.i_Blink_Mask;
`else
    km = 4'h0;
`endif
    bm = u_if.i_Blank_Mask;
    if (rst) begin
      e_seg = 7'h00; e_en = 4'hF; e_done = 1'b0;
      model_reset();
    end else begin
      d = m_cyc / CPD;
      s = m_cyc % CPD;
      up = m_act >> (4 * d);
      dark = m_blank[d] || (d > 0 && up == 16'h0);
`ifdef SEG7_BLINK_EN
      dark = dark || (((m_frames / BF) % 2 == 1) && m_blink[d]);
`endif
      nv = up[3:0];
      e_seg = dark ? 7'h00 : glyph_tab[nv];
      e_en = (s < 1) ? 4'hF : ~(4'b0001 << d);
      wrap = (m_cyc == FRAME - 1);
      e_done = wrap;
      if (ld && wrap) begin
        m_act = u_if.i_Value; m_blank = bm; m_blink = km; m_flag = 1'b0;
      end else if (ld) begin
        m_pend = u_if.i_Value; m_pblank = bm; m_pblink = km; m_flag = 1'b1;
      end else if (wrap && m_flag) begin
        m_act = m_pend; m_blank = m_pblank; m_blink = m_pblink; m_flag = 1'b0;
      end
      if (wrap) m_frames++;
      m_cyc = (m_cyc + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    u_if.i_Load = 1'b0;
    n_vec++;
    assert (u_if.o_Segment === e_seg) else begin
      n_err++;
      $error("FAIL seg t=%0t got %h exp %h", $time, u_if.o_Segment, e_seg);
    end
    n_vec++;
    assert (u_if.o_Digit_En === e_en) else begin
      n_err++;
      $error("FAIL digit_en t=%0t got %b exp %b", $time, u_if.o_Digit_En, e_en);
    end
    n_vec++;
    assert (u_if.o_Frame_Done === e_done) else begin
      n_err++;
      $error("FAIL frame_done t=%0t got %b exp %b", $time, u_if.o_Frame_Done, e_done);
    end
  endtask

  // Step until the model sits at frame position c (bounded to two frames).
  task automatic run_to(input int c);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_cyc != c && n < 2 * FRAME);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] km);
    u_if.i_Load = 1'b1;
    u_if.i_Value = v;
    u_if.i_Blank_Mask = bm;
`ifdef SEG7_BLINK_EN
    u_if.i_Blink_Mask = km;
`else
    if (km != 4'h0) $display("note: blink mask ignored in this build");
`endif
  endtask

  // Direct check of the pins against literal values from the display rules.
  task automatic spot(input string tag, input logic [6:0] seg, input logic [3:0] en);
    n_vec++;
    assert (u_if.o_Segment === seg) else begin
      n_err++;
      $error("FAIL %s seg got %h exp %h", tag, u_if.o_Segment, seg);
    end
    n_vec++;
    assert (u_if.o_Digit_En === en) else begin
      n_err++;
      $error("FAIL %s en got %b exp %b", tag, u_if.o_Digit_En, en);
    end
  endtask

  initial begin
    u_if.i_Load = 1'b0;
    u_if.i_Value = 16'h0;
    u_if.i_Blank_Mask = 4'h0;
`ifdef SEG7_BLINK_EN
    u_if.i_Blink_Mask = 4'h0;
`endif
    model_reset();
    rst = 1'b1;
    step(); step();
    spot("reset", 7'h00, 4'hF);
    rst = 1'b0;

    // 1234 loaded at frame start shows from the next frame.
    load(16'h1234, 4'h0, 4'h0);
    run_to(0);
    n_vec++;
    assert (u_if.o_Frame_Done === 1'b1) else begin
      n_err++;
      $error("FAIL frame_pulse got %b exp 1", u_if.o_Frame_Done);
    end
    run_to(2);  spot("d0_1234", 7'h33, 4'b1110);
    run_to(26); spot("d3_1234", 7'h30, 4'b0111);
    run_to(0);

    // Leading zeros dark, enables still cycling.
    load(16'h0005, 4'h0, 4'h0);
    run_to(0);
    run_to(2);  spot("d0_0005", 7'h5B, 4'b1110);
    run_to(10); spot("d1_0005", 7'h00, 4'b1101);
    run_to(0);
    load(16'h0000, 4'h0, 4'h0);
    run_to(0);
    run_to(2);  spot("d0_0000", 7'h7E, 4'b1110);
    run_to(18); spot("d2_0000", 7'h00, 4'b1011);

    // Mid-frame loads: last one wins, current frame unchanged.
    run_to(10);
    load(16'hAAAA, 4'h0, 4'h0);
    step(); step();
    load(16'hBBBB, 4'h0, 4'h0);
    run_to(26); spot("hold_0000", 7'h00, 4'b0111);
    run_to(2);  spot("d0_bbbb", 7'h1F, 4'b1110);
    run_to(26); spot("d3_bbbb", 7'h1F, 4'b0111);

    // Load coincident with the frame wrap takes effect directly.
    run_to(FRAME - 1);
    load(16'hFFFF, 4'h0, 4'h0);
    step();
    run_to(2);  spot("d0_ffff", 7'h47, 4'b1110);
    run_to(26); spot("d3_ffff", 7'h47, 4'b0111);
    run_to(0);

    // Per-digit blank, then reset in the middle of digit 2.
    load(16'h8888, 4'b0100, 4'h0);
    run_to(0);
    run_to(10); spot("d1_8888", 7'h7F, 4'b1101);
    run_to(18); spot("d2_blank", 7'h00, 4'b1011);
    run_to(20);
    rst = 1'b1;
    step();
    spot("mid_reset", 7'h00, 4'hF);
    rst = 1'b0;
    step(); spot("restart_dead", 7'h7E, 4'hF);
    step(); spot("restart_d0", 7'h7E, 4'b1110);

`ifdef SEG7_BLINK_EN
    // Blink digit 0 over several frames.
    run_to(0);
    load(16'h1111, 4'h0, 4'b0001);
    for (int f = 0; f < 6 * FRAME; f++) step();
`endif

    // Randomized loads, masks and occasional resets against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        load($urandom() >> (4 * $urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0,
             4'($urandom()));
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
